// File: rtl/cntrl_pkg.sv
// Shared types and constants for the pipelined control unit.
// Latency: n/a (types, constants and a pure match helper only).
// Backpressure: n/a.
package cntrl_pkg;

  localparam int OPC_WIDTH = 11;
  localparam int ALU_WIDTH = 3;
  localparam int RA_WIDTH  = 5;

  localparam logic [RA_WIDTH-1:0] XZR = 5'd31;

  // ALU operation encodings
  localparam logic [ALU_WIDTH-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_WIDTH-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_WIDTH-1:0] ALU_SUB  = 3'b011;
  localparam logic [ALU_WIDTH-1:0] ALU_MUL  = 3'b100;
  localparam logic [ALU_WIDTH-1:0] ALU_LSL  = 3'b101;
  localparam logic [ALU_WIDTH-1:0] ALU_LSR  = 3'b110;

  // Opcode match values; the mask marks the bits that must match.
  localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 11'b10010001000;
  localparam logic [OPC_WIDTH-1:0] OPC_ADDS = 11'b10101011000;
  localparam logic [OPC_WIDTH-1:0] OPC_SUBS = 11'b11101011000;
  localparam logic [OPC_WIDTH-1:0] OPC_MUL  = 11'b10011011000;
  localparam logic [OPC_WIDTH-1:0] OPC_LSL  = 11'b11010011011;
  localparam logic [OPC_WIDTH-1:0] OPC_LSR  = 11'b11010011010;
  localparam logic [OPC_WIDTH-1:0] OPC_B    = 11'b00010100000;
  localparam logic [OPC_WIDTH-1:0] OPC_CBZ  = 11'b10110100000;
  localparam logic [OPC_WIDTH-1:0] OPC_BLT  = 11'b01010100000;
  localparam logic [OPC_WIDTH-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_WIDTH-1:0] OPC_STUR = 11'b11111000000;

  localparam logic [OPC_WIDTH-1:0] MSK_FULL = 11'b11111111111;
  localparam logic [OPC_WIDTH-1:0] MSK_ADDI = 11'b11111111110;
  localparam logic [OPC_WIDTH-1:0] MSK_B    = 11'b11111100000;
  localparam logic [OPC_WIDTH-1:0] MSK_CB   = 11'b11111111000;

  typedef struct packed {
    logic                 reg_write;
    logic                 reg2loc;
    logic [ALU_WIDTH-1:0] alu_cntrl;
    logic                 alu_src;
    logic                 set_flags;
    logic                 mem_write;
    logic                 mem_read;
    logic                 mem_to_reg;
    logic                 is_branch;
    logic                 is_cbz;
    logic                 is_blt;
    logic                 is_mul;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Control bits still needed once an instruction leaves EX
  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                mem_read;
    logic                mem_to_reg;
    logic [RA_WIDTH-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                reg_write;
    logic                mem_to_reg;
    logic [RA_WIDTH-1:0] rd;
  } memwb_t;

  function automatic logic opc_match(input logic [OPC_WIDTH-1:0] opc,
                                     input logic [OPC_WIDTH-1:0] val,
                                     input logic [OPC_WIDTH-1:0] msk);
    return ((opc ^ val) & msk) == '0;
  endfunction

endpackage

// File: rtl/cntrl_decode.sv
// Opcode decoder: maps the ID-stage opcode to a ctrl_t bundle and an illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the opcode every cycle.
// Ports: opcode (in, 11b) -> ctrl (ctrl_t), illegal (1b, unrecognised opcode).
module cntrl_decode
  import cntrl_pkg::*;
(
  input  logic [OPC_WIDTH-1:0] opcode,
  output ctrl_t                ctrl,
  output logic                 illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    if (opc_match(opcode, OPC_ADDI, MSK_ADDI)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_cntrl = ALU_ADD;
      ctrl.alu_src   = 1'b1;
    end else if (opc_match(opcode, OPC_ADDS, MSK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_cntrl = ALU_ADD;
      ctrl.set_flags = 1'b1;
    end else if (opc_match(opcode, OPC_SUBS, MSK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_cntrl = ALU_SUB;
      ctrl.set_flags = 1'b1;
    end else if (opc_match(opcode, OPC_MUL, MSK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_cntrl = ALU_MUL;
      ctrl.is_mul    = 1'b1;
    end else if (opc_match(opcode, OPC_LSL, MSK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_cntrl = ALU_LSL;
      ctrl.alu_src   = 1'b1;
    end else if (opc_match(opcode, OPC_LSR, MSK_FULL)) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu_cntrl = ALU_LSR;
      ctrl.alu_src   = 1'b1;
    end else if (opc_match(opcode, OPC_B, MSK_B)) begin
      ctrl.is_branch = 1'b1;
    end else if (opc_match(opcode, OPC_CBZ, MSK_CB)) begin
      ctrl.reg2loc   = 1'b1;
      ctrl.alu_cntrl = ALU_PASS;
      ctrl.is_cbz    = 1'b1;
    end else if (opc_match(opcode, OPC_BLT, MSK_CB)) begin
      ctrl.is_branch = 1'b1;
      ctrl.is_blt    = 1'b1;
    end else if (opc_match(opcode, OPC_LDUR, MSK_FULL)) begin
      ctrl.reg_write  = 1'b1;
      ctrl.alu_cntrl  = ALU_ADD;
      ctrl.alu_src    = 1'b1;
      ctrl.mem_read   = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg2loc    = 1'b1;
    end else if (opc_match(opcode, OPC_STUR, MSK_FULL)) begin
      ctrl.alu_cntrl = ALU_ADD;
      ctrl.alu_src   = 1'b1;
      ctrl.mem_write = 1'b1;
      ctrl.reg2loc   = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_cntrl.sv
// Pipelined control: decode in ID, control carried ID/EX->EX/MEM->MEM/WB, NZCV, branches, hazards.
// Latency: decode/branch/stall combinational in ID; ex_* +1, mem_* +2, wb_* +3 cycles (plus MUL hold).
// Backpressure: pc_stall holds PC and IF/ID; ex_hold freezes ID/EX for MUL_LAT-1 cycles, bubbling EX/MEM.
// Ports: clk, reset (sync, active high); id_* opcode/regs and id_cbz_zero from IF/ID; ex_n/z/v/c ALU
//   flags of the EX instruction; outputs id_reg2loc, br_taken, pc_stall, ifid_flush, ex_*, mem_*, wb_*,
//   flags_q (NZCV: [3]=N [2]=Z [1]=C [0]=V), illegal.
// Optional: define PIPE_CNTRL_PERF_EN to add saturating perf_stall_cnt / perf_flush_cnt outputs.
module pipe_cntrl
  import cntrl_pkg::*;
#(
  parameter int OPC_W   = 11,
  parameter int ALU_W   = 3,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3   // legal range 1..8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_cbz_zero,
  input  logic              ex_n,
  input  logic              ex_z,
  input  logic              ex_v,
  input  logic              ex_c,
  output logic              id_reg2loc,
  output logic              br_taken,
  output logic              pc_stall,
  output logic              ifid_flush,
  output logic [ALU_W-1:0]  ex_alu_cntrl,
  output logic              ex_alu_src,
  output logic              ex_set_flags,
  output logic              ex_hold,
  output logic              mem_write,
  output logic              mem_read,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [3:0]        flags_q,
`ifdef PIPE_CNTRL_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              illegal
);

  localparam logic [2:0] MUL_CNT_INIT = 3'(MUL_LAT - 1);

  ctrl_t             ctrl_id;
  ctrl_t             idex_ctrl;
  logic [REG_AW-1:0] idex_rd;
  exmem_t            exmem_q;
  memwb_t            memwb_q;
  logic [2:0]        mul_cnt;

  logic              hold;
  logic [REG_AW-1:0] src2;
  logic              src2_used;
  logic              load_use;
  logic              cbz_hazard;
  logic              stall;
  logic              n_fwd;
  logic              v_fwd;
  logic              taken;
  logic              id_branch;

  cntrl_decode u_decode (
    .opcode  (id_opcode),
    .ctrl    (ctrl_id),
    .illegal (illegal)
  );

  assign hold = (mul_cnt != 3'd0);

  // Second read port carries Rt for CBZ/STUR; only consumed by reg-reg ALU ops, STUR data and CBZ.
  assign src2      = ctrl_id.reg2loc ? id_rd : id_rm;
  assign src2_used = ctrl_id.mem_write | ctrl_id.is_cbz | (ctrl_id.reg_write & ~ctrl_id.alu_src);

  assign load_use = idex_ctrl.mem_read && (idex_rd != XZR) &&
                    ((idex_rd == id_rn) || (src2_used && (idex_rd == src2)));

  // CBZ resolves in ID, so it cannot use an EX result or a load still in MEM.
  assign cbz_hazard = ctrl_id.is_cbz && (id_rd != XZR) &&
                      ((idex_ctrl.reg_write && (idex_rd == id_rd)) ||
                       (exmem_q.mem_read && (exmem_q.rd == id_rd)));

  assign stall = load_use | cbz_hazard;

  // B.LT sees the flags of a flag-setting instruction in EX before they are architectural.
  assign n_fwd = idex_ctrl.set_flags ? ex_n : flags_q[3];
  assign v_fwd = idex_ctrl.set_flags ? ex_v : flags_q[0];

  assign taken = (ctrl_id.is_branch & ~ctrl_id.is_blt) |
                 (ctrl_id.is_cbz & id_cbz_zero) |
                 (ctrl_id.is_blt & (n_fwd ^ v_fwd));

  assign id_branch  = ctrl_id.is_branch | ctrl_id.is_cbz;
  assign br_taken   = taken & ~hold & ~stall;
  assign ifid_flush = br_taken;
  assign pc_stall   = hold | stall;
  assign id_reg2loc = ctrl_id.reg2loc;

  assign ex_alu_cntrl  = idex_ctrl.alu_cntrl;
  assign ex_alu_src    = idex_ctrl.alu_src;
  assign ex_set_flags  = idex_ctrl.set_flags;
  assign ex_hold       = hold;
  assign mem_write     = exmem_q.mem_write;
  assign mem_read      = exmem_q.mem_read;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_rd         = memwb_q.rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ctrl <= CTRL_NOP;
      idex_rd   <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      mul_cnt   <= '0;
      flags_q   <= '0;
    end else begin
      if (idex_ctrl.set_flags && !hold) begin
        flags_q <= {ex_n, ex_z, ex_c, ex_v};
      end
      memwb_q <= '{reg_write: exmem_q.reg_write, mem_to_reg: exmem_q.mem_to_reg, rd: exmem_q.rd};
      if (hold) begin
        // MUL iterates in EX: ID/EX frozen, a bubble goes down to MEM.
        exmem_q <= '0;
        mul_cnt <= mul_cnt - 3'd1;
      end else begin
        exmem_q <= '{reg_write:  idex_ctrl.reg_write,
                     mem_write:  idex_ctrl.mem_write,
                     mem_read:   idex_ctrl.mem_read,
                     mem_to_reg: idex_ctrl.mem_to_reg,
                     rd:         idex_rd};
        if (stall) begin
          idex_ctrl <= CTRL_NOP;
          idex_rd   <= '0;
          mul_cnt   <= '0;
        end else begin
          // Branches are finished in ID and travel on as NOPs.
          idex_ctrl <= id_branch ? CTRL_NOP : ctrl_id;
          idex_rd   <= id_rd;
          mul_cnt   <= ctrl_id.is_mul ? MUL_CNT_INIT : 3'd0;
        end
      end
    end
  end

`ifdef PIPE_CNTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (ifid_flush && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  // Branch/MUL tags are not needed past ID; kept in the struct for a uniform bundle.
  logic unused_idex;
  assign unused_idex = ^{idex_ctrl.reg2loc, idex_ctrl.mem_to_reg & 1'b0, idex_ctrl.is_branch,
                         idex_ctrl.is_cbz, idex_ctrl.is_blt, idex_ctrl.is_mul};

endmodule

// File: tb/tb_pipe_cntrl.sv
module tb_pipe_cntrl;

  localparam int MUL_LAT = 3;

  typedef enum logic [3:0] {
    K_NOP, K_ADDI, K_ADDS, K_SUBS, K_MUL, K_LSL, K_LSR,
    K_B, K_CBZ, K_BLT, K_LDUR, K_STUR, K_ILL
  } kind_e;

  typedef struct packed {
    kind_e      k;
    logic [4:0] rd;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] id_opcode = '0;
  logic [4:0]  id_rd = '0, id_rn = '0, id_rm = '0;
  logic        id_cbz_zero = 1'b0;
  logic        ex_n = 1'b0, ex_z = 1'b0, ex_v = 1'b0, ex_c = 1'b0;
  logic        id_reg2loc, br_taken, pc_stall, ifid_flush;
  logic [2:0]  ex_alu_cntrl;
  logic        ex_alu_src, ex_set_flags, ex_hold, mem_write, mem_read;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic [3:0]  flags_q;
  logic        illegal;
`ifdef PIPE_CNTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_cntrl #(.OPC_W(11), .ALU_W(3), .REG_AW(5), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
    .id_cbz_zero(id_cbz_zero), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v), .ex_c(ex_c),
    .id_reg2loc(id_reg2loc), .br_taken(br_taken), .pc_stall(pc_stall), .ifid_flush(ifid_flush),
    .ex_alu_cntrl(ex_alu_cntrl), .ex_alu_src(ex_alu_src), .ex_set_flags(ex_set_flags),
    .ex_hold(ex_hold), .mem_write(mem_write), .mem_read(mem_read), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .flags_q(flags_q),
`ifdef PIPE_CNTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] ill_list [4] = '{11'b00000000000, 11'b11111111111, 11'b10001011000, 11'b11010011000};
  int          ill_idx = 0;

  // Reference pipeline: one instruction record per stage, flags and MUL cycles left
  slot_t       m_ex, m_mem, m_wb;
  int          m_hold = 0;
  logic [3:0]  m_flags = '0;
  logic [31:0] m_sc = '0, m_fc = '0;
  bit          m_valid = 0;

  // Values seen on the DUT at the last sample point
  logic       last_br, last_flush, last_stall, last_hold, last_ill, last_r2l;
  logic [4:0] last_ex;
  logic [1:0] last_mem;
  logic [6:0] last_wb;
  logic [3:0] last_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic writes(input kind_e k);
    return k inside {K_ADDI, K_ADDS, K_SUBS, K_MUL, K_LSL, K_LSR, K_LDUR};
  endfunction

  function automatic logic [2:0] alu_of(input kind_e k);
    case (k)
      K_ADDI, K_ADDS, K_LDUR, K_STUR: return 3'b010;
      K_SUBS: return 3'b011;
      K_MUL:  return 3'b100;
      K_LSL:  return 3'b101;
      K_LSR:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic imm_of(input kind_e k);
    return k inside {K_ADDI, K_LSL, K_LSR, K_LDUR, K_STUR};
  endfunction

  function automatic logic setf(input kind_e k);
    return k inside {K_ADDS, K_SUBS};
  endfunction

  function automatic logic [10:0] opc_of(input kind_e k);
    logic [10:0] o;
    case (k)
      K_ADDI: o = {10'b1001000100, 1'($urandom_range(0, 1))};
      K_ADDS: o = 11'b10101011000;
      K_SUBS: o = 11'b11101011000;
      K_MUL:  o = 11'b10011011000;
      K_LSL:  o = 11'b11010011011;
      K_LSR:  o = 11'b11010011010;
      K_B:    o = {6'b000101, 5'($urandom_range(0, 31))};
      K_CBZ:  o = {8'b10110100, 3'($urandom_range(0, 7))};
      K_BLT:  o = {8'b01010100, 3'($urandom_range(0, 7))};
      K_LDUR: o = 11'b11111000010;
      K_STUR: o = 11'b11111000000;
      default: o = ill_list[ill_idx];
    endcase
    return o;
  endfunction

  // One cycle: drive at negedge, compare 1ns later, advance the model at posedge.
  task automatic step(input kind_e k, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                      input logic cz, input logic [3:0] nzcv, input logic rst);
    logic hold, lu, cb, stl, tk, ebr, n_eff, v_eff, two;
    logic [4:0] s2;
    @(negedge clk);
    reset = rst; id_opcode = opc_of(k); id_rd = rd; id_rn = rn; id_rm = rm; id_cbz_zero = cz;
    ex_n = nzcv[3]; ex_z = nzcv[2]; ex_c = nzcv[1]; ex_v = nzcv[0];
    #1;
    hold  = (m_hold > 0);
    two   = k inside {K_ADDS, K_SUBS, K_MUL, K_STUR, K_CBZ};
    s2    = (k inside {K_STUR, K_CBZ}) ? rd : rm;
    lu    = (m_ex.k == K_LDUR) && (m_ex.rd != 5'd31) && ((m_ex.rd == rn) || (two && (m_ex.rd == s2)));
    cb    = (k == K_CBZ) && (rd != 5'd31) &&
            ((writes(m_ex.k) && (m_ex.rd == rd)) || ((m_mem.k == K_LDUR) && (m_mem.rd == rd)));
    stl   = lu || cb;
    n_eff = setf(m_ex.k) ? nzcv[3] : m_flags[3];
    v_eff = setf(m_ex.k) ? nzcv[0] : m_flags[0];
    tk    = (k == K_B) || ((k == K_CBZ) && cz) || ((k == K_BLT) && (n_eff != v_eff));
    ebr   = tk && !hold && !stl;
    last_br = br_taken; last_flush = ifid_flush; last_stall = pc_stall; last_hold = ex_hold;
    last_ill = illegal; last_r2l = id_reg2loc; last_ex = {ex_alu_cntrl, ex_alu_src, ex_set_flags};
    last_mem = {mem_write, mem_read}; last_wb = {wb_reg_write, wb_mem_to_reg, wb_rd}; last_flags = flags_q;
    if (m_valid) begin
      chk("id_decode", {illegal, id_reg2loc}, {k == K_ILL, k inside {K_CBZ, K_LDUR, K_STUR}});
      chk("branch", {br_taken, ifid_flush}, {ebr, ebr});
      chk("pc_stall", pc_stall, hold || stl);
      chk("ex_hold", ex_hold, hold);
      chk("ex_ctrl", {ex_alu_cntrl, ex_alu_src, ex_set_flags}, {alu_of(m_ex.k), imm_of(m_ex.k), setf(m_ex.k)});
      chk("mem_ctrl", {mem_write, mem_read}, {m_mem.k == K_STUR, m_mem.k == K_LDUR});
      chk("wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, {writes(m_wb.k), m_wb.k == K_LDUR, m_wb.rd});
      chk("flags_q", flags_q, m_flags);
`ifdef PIPE_CNTRL_PERF_EN
      chk("perf_stall", perf_stall_cnt, m_sc);
      chk("perf_flush", perf_flush_cnt, m_fc);
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_ex = '{k: K_NOP, rd: 5'd0}; m_mem = m_ex; m_wb = m_ex;
      m_hold = 0; m_flags = '0; m_sc = '0; m_fc = '0; m_valid = 1;
    end else begin
      if ((hold || stl) && (m_sc != 32'hFFFF_FFFF)) m_sc = m_sc + 1;
      if (ebr && (m_fc != 32'hFFFF_FFFF)) m_fc = m_fc + 1;
      if (setf(m_ex.k) && !hold) m_flags = nzcv;
      m_wb = m_mem;
      if (hold) begin
        m_mem = '{k: K_NOP, rd: 5'd0};
        m_hold = m_hold - 1;
      end else begin
        m_mem = m_ex;
        if (stl) m_ex = '{k: K_NOP, rd: 5'd0};
        else if (k inside {K_B, K_CBZ, K_BLT, K_ILL}) m_ex = '{k: K_NOP, rd: rd};
        else m_ex = '{k: k, rd: rd};
        m_hold = (!stl && (k == K_MUL)) ? MUL_LAT - 1 : 0;
      end
    end
  endtask

  function automatic logic [4:0] rr();
    return ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    int hold_cycles;
    m_ex = '{k: K_NOP, rd: 5'd0}; m_mem = m_ex; m_wb = m_ex;

    // Reset with LDUR X5 on the input, then release
    step(K_LDUR, 5'd5, 5'd1, 5'd2, 1'b0, 4'h0, 1'b1);
    step(K_LDUR, 5'd5, 5'd1, 5'd2, 1'b0, 4'h0, 1'b1);
    chk("reset_regs_zero", {last_ex, last_mem, last_wb, last_flags, last_hold}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(K_LDUR, 5'd5, 5'd1, 5'd2, 1'b0, 4'h0, 1'b0);
      if (i == 2) chk("ldur_not_yet_wb", last_wb, 32'd0);
    end
    chk("ldur_wb_after_3", last_wb, {1'b1, 1'b1, 5'd5});

    // SUBS sets N in EX while B.LT resolves in ID
    step(K_SUBS, 5'd2, 5'd1, 5'd4, 1'b0, 4'h0, 1'b0);
    step(K_BLT, 5'd0, 5'd0, 5'd0, 1'b0, 4'b1000, 1'b0);
    chk("blt_fwd_taken", {last_br, last_flush}, 2'b11);
    chk("flags_before_edge", last_flags, 4'h0);
    step(K_ILL, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0, 1'b0);
    chk("flags_after_subs", last_flags, 4'b1000);
    step(K_BLT, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0, 1'b0);
    chk("blt_arch_flags_taken", last_br, 1'b1);

    // Load-use: LDUR X3 then ADDS X4, X3, X2
    step(K_ILL, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0, 1'b1);
    step(K_LDUR, 5'd3, 5'd1, 5'd0, 1'b0, 4'h0, 1'b0);
    step(K_ADDS, 5'd4, 5'd3, 5'd2, 1'b0, 4'h0, 1'b0);
    chk("load_use_stall", last_stall, 1'b1);
    step(K_ADDS, 5'd4, 5'd3, 5'd2, 1'b0, 4'h0, 1'b0);
    chk("load_use_one_cycle", last_stall, 1'b0);
    chk("load_use_bubble", last_ex, 5'd0);
    step(K_LDUR, 5'd31, 5'd1, 5'd0, 1'b0, 4'h0, 1'b0);
    chk("adds_in_ex", last_ex, {3'b010, 1'b0, 1'b1});
    step(K_ADDS, 5'd4, 5'd31, 5'd2, 1'b0, 4'h0, 1'b0);
    chk("xzr_no_stall", last_stall, 1'b0);
`ifdef PIPE_CNTRL_PERF_EN
    chk("perf_stall_one", perf_stall_cnt, 32'd1);
`endif

    // MUL X7 followed by ADDI X8
    step(K_MUL, 5'd7, 5'd1, 5'd2, 1'b0, 4'h0, 1'b0);
    chk("mul_in_id_no_hold", last_hold, 1'b0);
    hold_cycles = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 3) step(K_ADDI, 5'd8, 5'd9, 5'd0, 1'b0, 4'h0, 1'b0);
      else        step(K_ILL, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0, 1'b0);
      if (last_hold) hold_cycles++;
      if (i == 3) chk("mul_last_ex_cycle", last_ex, {3'b100, 1'b0, 1'b0});
      if (i == 4) chk("addi_in_ex", last_ex, {3'b010, 1'b1, 1'b0});
      if (i == 5) chk("mul_wb", last_wb, {1'b1, 1'b0, 5'd7});
      if (i == 6) chk("addi_wb_next", last_wb, {1'b1, 1'b0, 5'd8});
    end
    chk("mul_hold_cycles", hold_cycles, 32'd2);

    // CBZ X10 right behind a write of X10
    step(K_ADDI, 5'd10, 5'd1, 5'd0, 1'b0, 4'h0, 1'b0);
    step(K_CBZ, 5'd10, 5'd0, 5'd0, 1'b1, 4'h0, 1'b0);
    chk("cbz_stall", {last_stall, last_br}, 2'b10);
    step(K_CBZ, 5'd10, 5'd0, 5'd0, 1'b1, 4'h0, 1'b0);
    chk("cbz_taken_after", {last_stall, last_br, last_flush}, 3'b011);

    // All-zero opcode
    ill_idx = 0;
    step(K_ILL, 5'd5, 5'd6, 5'd7, 1'b0, 4'h0, 1'b0);
    chk("illegal_zero_opc", {last_ill, last_r2l, last_br, last_stall}, 4'b1000);
    step(K_ILL, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0, 1'b0);
    chk("illegal_ex_nop", last_ex, 5'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 2000; c++) begin
      kind_e k;
      k = kind_e'($urandom_range(1, 12));
      ill_idx = $urandom_range(0, 3);
      step(k, rr(), rr(), rr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cntrl.md
Name: pipe_cntrl

Overview:
- Pipelined successor to the single-cycle control decoder for the 5-stage ARMv8 subset CPU.
- Decodes the 11-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Owns the NZCV flag register and resolves branches in ID.
- Generates load-use stalls, multi-cycle MUL stalls and IF/ID flushes.

Parameters:
- OPC_W, 11, opcode field width.
- ALU_W, 3, ALU control width. Encodings: 000 pass B, 010 add, 011 sub, 100 mul, 101 lsl, 110 lsr.
- REG_AW, 5, register address width. Register 31 (all ones) is XZR and never causes a hazard.
- MUL_LAT, 3, cycles MUL occupies EX. Legal range is 1 to 8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- id_opcode  in  OPC_W  inst[31:21] of the IF/ID instruction.
- id_rd  in  REG_AW  inst[4:0]; destination, or Rt for STUR/CBZ.
- id_rn  in  REG_AW  inst[9:5].
- id_rm  in  REG_AW  inst[20:16].
- id_cbz_zero  in  1  forwarded ID-stage Rt==0 indication from the datapath.
- ex_n, ex_z, ex_v, ex_c  in  1  ALU flags of the instruction currently in EX.
- id_reg2loc  out  1  read port 2 select: 1 selects Rd/Rt, 0 selects Rm.
- br_taken  out  1  branch redirect this cycle.
- pc_stall  out  1  hold PC and IF/ID.
- ifid_flush  out  1  zero IF/ID on the next edge.
- ex_alu_cntrl  out  ALU_W  ALU operation.
- ex_alu_src  out  1  ALU operand B: 1 selects immediate.
- ex_set_flags  out  1  EX instruction sets flags.
- ex_hold  out  1  hold ID/EX while MUL iterates.
- mem_write  out  1  data memory write.
- mem_read  out  1  data memory read.
- wb_reg_write  out  1  register file write enable.
- wb_mem_to_reg  out  1  WB data select: 1 selects memory.
- wb_rd  out  REG_AW  WB destination register.
- flags_q  out  4  architectural NZCV.
- illegal  out  1  unrecognised opcode in ID.

Behaviour:
- Decode table, matched in ID; every field not listed is 0:
  - ADDI 1001000100x: rw, add, src.
  - ADDS 10101011000: rw, add, set.
  - SUBS 11101011000: rw, sub, set.
  - MUL 10011011000: rw, mul.
  - LSL 11010011011: rw, lsl, src.
  - LSR 11010011010: rw, lsr, src.
  - B 000101xxxxx: branch.
  - CBZ 10110100xxx: reg2loc, pass B.
  - B.LT 01010100xxx: branch.
  - LDUR 11111000010: rw, add, src, mr, m2r, reg2loc.
  - STUR 11111000000: add, src, mw, reg2loc.
- Any other opcode decodes as an all-zero NOP and raises illegal. Outputs are never X or Z.
- Branches (combinational in ID):
  - B is always taken.
  - CBZ is taken when id_cbz_zero=1.
  - B.LT is taken when N!=V. N and V come from ex_n/ex_v if ex_set_flags=1 (forwarding); otherwise from flags_q.
  - ifid_flush equals br_taken. The branch itself continues down the pipe as a NOP.
- Flags: flags_q loads {ex_n,ex_z,ex_c,ex_v} on an edge where ex_set_flags=1 and ex_hold=0.
- Load-use stall: raise pc_stall when ID/EX holds a load with ex_rd != 31, and ex_rd equals id_rn or the selected source-2 register (when that source is used).
- CBZ stall: also stall when the ID instruction is CBZ and EX holds a write to its Rt, or MEM holds a load to its Rt.
- During a load-use or CBZ stall: ID/EX loads a bubble (all-zero), and br_taken and ifid_flush are forced to 0.
- MUL sequencing: a 3-bit counter loads MUL_LAT-1 when a MUL enters EX.
  - While the counter is nonzero: ex_hold=1, pc_stall=1, a bubble enters EX/MEM, and the counter decrements.
  - The MUL advances to MEM on the cycle the counter reaches 0.
  - MUL_LAT=1 means no hold.
- Priority: MUL hold > load-use/CBZ stall > branch flush.
- EX/MEM and MEM/WB always advance except under ex_hold, which bubbles EX/MEM only.
- Reset, synchronous: all stage control bits 0, wb_rd=0, flags_q=0, counter 0. All registered outputs read 0 on the cycle after reset. Reset during a MUL hold aborts the MUL.

Optional Feature:
- Macro: PIPE_CNTRL_PERF_EN.
- When defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on each cycle with pc_stall=1.
  - perf_flush_cnt increments on each cycle with ifid_flush=1.
  - Both saturate at all ones and are cleared by reset.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package cntrl_pkg holds:
  - typedef struct packed ctrl_t {reg_write, reg2loc, alu_cntrl, alu_src, set_flags, mem_write, mem_read, mem_to_reg, is_branch, is_cbz, is_blt, is_mul}.
  - ALU op localparams.
  - Opcode match constants.
  - CTRL_NOP constant.
- Sub-module cntrl_decode: purely combinational opcode to ctrl_t and illegal. The pipeline registers, hazard logic, flags register and MUL counter stay in pipe_cntrl.

Test Plan:
1. Reset held 2 cycles with a LDUR opcode on input → all stage outputs and flags_q are 0; 3 cycles after release, wb_mem_to_reg=1 and wb_rd=id_rd.
2. SUBS (ex_n=1, ex_v=0) in EX with B.LT in ID → br_taken=1 and ifid_flush=1 that cycle; flags_q=4'b1000 after the edge.
3. LDUR to X3 followed by ADDS using Rn=X3 → pc_stall=1 for exactly 1 cycle and an all-zero ID/EX bubble; no stall when Rd=31.
4. MUL with MUL_LAT=3, then ADDI → ex_hold=1 for 2 cycles, MUL reaches wb_reg_write after 5 cycles total, and ADDI follows 1 cycle after it.
5. CBZ with id_cbz_zero=1 while EX writes its Rt → 1 stall cycle with br_taken=0; br_taken=1 on the following cycle.
6. Opcode 11'b00000000000 → illegal=1 and all controls 0. With PIPE_CNTRL_PERF_EN defined, rerun scenario 3 → perf_stall_cnt=1.
